// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// Holds the FSM state encoding, the default data-memory base and the SRAM bus width.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  localparam int unsigned DefaultBaseAddr = 1024;
  localparam int unsigned SramDataW       = 16;
  localparam int unsigned WaitCntW        = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times one half-word SRAM phase.
// o_last flags the final cycle of a phase; o_last_next flags the cycle before it.
module mem_wait_counter
  import sram_mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [WaitCntW-1:0] i_load_val,
  output logic                o_last,
  output logic                o_last_next
);

  logic [WaitCntW-1:0] r_cnt;

  // Saturates at zero so the count stays parked while the FSM is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WaitCntW'(1);
    end
  end

  assign o_last      = (r_cnt == '0);
  assign o_last_next = (r_cnt == WaitCntW'(1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage responder: splits each 32-bit load/store into two 16-bit accesses to an
// asynchronous SRAM and holds ready low to freeze the pipeline until the access completes.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SramDataW-1:0]   sram_dq_o,
  input  logic [SramDataW-1:0]   sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam logic [WaitCntW-1:0] LoadVal = WaitCntW'(WAIT_CYCLES - 1);

  state_e                 r_state;
  logic                   r_is_write;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SramDataW-1:0]   r_dq_o;
  logic                   r_dq_oe;
  logic                   r_we_n;

  logic                   w_req;
  logic [31:0]            w_src_addr;
  logic [SRAM_ADDR_W-1:0] w_lo_addr;
  logic [SRAM_ADDR_W-1:0] w_hi_addr;
  logic                   w_cnt_load;
  logic                   w_last;
  logic                   w_last_next;

  assign w_req = mem_r_en | mem_w_en;

  // In IDLE the live request address is mapped so LO can start on the very next edge.
  assign w_src_addr = (r_state == StIdle) ? addr : r_addr;
  assign w_lo_addr  = SRAM_ADDR_W'(((w_src_addr - 32'(BASE_ADDR)) >> 1) & ~32'd1);
  assign w_hi_addr  = w_lo_addr | SRAM_ADDR_W'(1);

  assign w_cnt_load = ((r_state == StIdle) && w_req) || ((r_state == StLo) && w_last);

  mem_wait_counter u_wait_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_cnt_load),
    .i_load_val  (LoadVal),
    .o_last      (w_last),
    .o_last_next (w_last_next)
  );

  // Strobe outputs are registered, so each decision is made one cycle ahead: we_n rises
  // on the edge entering the final cycle of a phase to give the SRAM data hold time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_state     <= StLo;
            r_is_write  <= mem_w_en;
            r_addr      <= addr;
            r_wdata     <= wdata;
            r_sram_addr <= w_lo_addr;
            r_dq_o      <= wdata[15:0];
            r_dq_oe     <= mem_w_en;
            r_we_n      <= ~mem_w_en;
          end
        end
        StLo: begin
          if (w_last) begin
            r_state     <= StHi;
            r_sram_addr <= w_hi_addr;
            r_dq_o      <= r_wdata[31:16];
            r_we_n      <= ~r_is_write;
            if (!r_is_write) begin
              r_rdata[15:0] <= sram_dq_i;
            end
          end else if (w_last_next) begin
            r_we_n <= 1'b1;
          end
        end
        StHi: begin
          if (w_last) begin
            r_state <= StDone;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            if (!r_is_write) begin
              r_rdata[31:16] <= sram_dq_i;
            end
          end else if (w_last_next) begin
            r_we_n <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ready = 1'b0;
    unique case (r_state)
      StIdle:  ready = ~w_req;
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rdata      = r_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_we_n  = r_we_n;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: a word-level reference memory predicts each access,
// a negedge monitor checks completion timing, strobes, addresses and load data.
module tb_sram_mem_ctrl;

  localparam int TbW = 2;

  typedef struct {
    bit          is_store;
    logic [31:0] rdata;
    logic [17:0] lo_addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mem_clr;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;

  logic        mem_r_en4, mem_w_en4;
  logic [31:0] addr4, wdata4, rdata4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic [15:0] sram_dq_o4, sram_dq_i4;
  logic        sram_dq_oe4, sram_we_n4;

  logic [15:0] sram  [256];
  logic [15:0] sram4 [256];

  int          n_vec = 0;
  int          n_mis = 0;
  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] m_rdata;

  sram_mem_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(TbW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  sram_mem_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en4),
    .mem_w_en   (mem_w_en4),
    .addr       (addr4),
    .wdata      (wdata4),
    .rdata      (rdata4),
    .ready      (ready4),
    .sram_addr  (sram_addr4),
    .sram_dq_o  (sram_dq_o4),
    .sram_dq_i  (sram_dq_i4),
    .sram_dq_oe (sram_dq_oe4),
    .sram_we_n  (sram_we_n4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: write while we_n is low, read data appears one cycle after the address.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        sram[i]  <= 16'h0;
        sram4[i] <= 16'h0;
      end
      sram_dq_i  <= 16'h0;
      sram_dq_i4 <= 16'h0;
    end else begin
      if (!sram_we_n && sram_dq_oe) sram[sram_addr[7:0]] <= sram_dq_o;
      if (!sram_we_n4 && sram_dq_oe4) sram4[sram_addr4[7:0]] <= sram_dq_o4;
      sram_dq_i  <= sram[sram_addr[7:0]];
      sram_dq_i4 <= sram4[sram_addr4[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT completes a request.
  int          frz, wlow;
  bit          seen_w;
  logic [17:0] first_a, last_a;
  logic [15:0] first_d, last_d;
  logic [31:0] last_rdata;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      frz = 0; wlow = 0; seen_w = 0; last_rdata = 32'h0;
    end else if (mem_r_en | mem_w_en) begin
      if (!ready) begin
        frz++;
        if (!sram_we_n) begin
          wlow++;
          if (!seen_w) begin first_a = sram_addr; first_d = sram_dq_o; seen_w = 1; end
          last_a = sram_addr; last_d = sram_dq_o;
        end
      end else if (sb.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL unexpected_completion: got ready=1, expected no pending access");
        frz = 0; wlow = 0; seen_w = 0;
      end else begin
        e = sb.pop_front();
        chk("freeze_len", frz, 2 * TbW + 1);
        chk("we_low_cycles", wlow, e.is_store ? 2 * (TbW - 1) : 0);
        chk("rdata_done", rdata, e.rdata);
        if (e.is_store) begin
          chk("lo_addr", {14'h0, first_a}, {14'h0, e.lo_addr});
          chk("lo_data", {16'h0, first_d}, {16'h0, e.wdata[15:0]});
          chk("hi_addr", {14'h0, last_a}, {14'h0, e.lo_addr | 18'd1});
          chk("hi_data", {16'h0, last_d}, {16'h0, e.wdata[31:16]});
        end
        last_rdata = e.rdata;
        frz = 0; wlow = 0; seen_w = 0;
      end
    end else begin
      chk("idle_ready", {31'h0, ready}, 32'h1);
      chk("idle_we_n", {31'h0, sram_we_n}, 32'h1);
      chk("rdata_held", rdata, last_rdata);
    end
  end

  // op: 1 = load, 2 = store, 3 = both enables (behaves as a store)
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] wi;
    int          guard;
    wi         = (a - 32'd1024) >> 2;
    e.is_store = (op >= 2);
    e.lo_addr  = 18'(wi * 2);
    e.wdata    = d;
    if (e.is_store) begin
      ref_mem[int'(wi)] = d;
      e.rdata = m_rdata;
    end else begin
      e.rdata = ref_mem.exists(int'(wi)) ? ref_mem[int'(wi)] : 32'h0;
      m_rdata = e.rdata;
    end
    sb.push_back(e);
    mem_r_en = (op == 1) || (op == 3);
    mem_w_en = (op >= 2);
    addr     = a;
    wdata    = d;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!ready && guard < 40);
    if (!ready) begin
      n_vec++; n_mis++;
      $display("FAIL access_timeout: got no ready after %0d cycles, expected %0d", guard,
               2 * TbW + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    repeat (n) begin
      addr  = $urandom;
      wdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int          lowcnt, w0, w1, guard;

    rst = 1'b1; mem_clr = 1'b1; m_rdata = 32'h0;
    mem_r_en = 0; mem_w_en = 0; addr = 0; wdata = 0;
    mem_r_en4 = 0; mem_w_en4 = 0; addr4 = 0; wdata4 = 0;

    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sram_addr", {14'h0, sram_addr}, 32'h0);
    chk("rst_dq_o", {16'h0, sram_dq_o}, 32'h0);
    chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst_ready_noreq", {31'h0, ready}, 32'h1);
    mem_r_en = 1'b1;
    #1 chk("rst_ready_req", {31'h0, ready}, 32'h0);
    mem_r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
    idle(2);

    do_op(2, 32'd1028, 32'hDEADBEEF);
    idle(1);
    chk("sram_lo_word", {16'h0, sram[2]}, 32'h0000BEEF);
    chk("sram_hi_word", {16'h0, sram[3]}, 32'h0000DEAD);

    // Back-to-back: load then store in the IDLE cycle right after DONE.
    do_op(1, 32'd1028, 32'h0);
    do_op(2, 32'd1036, 32'hCAFE_F00D);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(1, 2));
      a  = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      do_op(op, a, $urandom);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    idle(10);

    // Reset during the second HI cycle of a store; both strobes have completed by then.
    a = 32'd1024 + 4 * 20;
    d = $urandom;
    mem_w_en = 1'b1; addr = a; wdata = d;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; mem_w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("abort_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_ready", {31'h0, ready}, 32'h1);
    chk("abort_lo_kept", {16'h0, sram[40]}, {16'h0, d[15:0]});
    ref_mem[20] = d;
    m_rdata = 32'h0;
    idle(1);
    do_op(1, a, 32'h0);
    idle(2);

    // WAIT_CYCLES = 4 instance: single store to word 0.
    mem_w_en4 = 1'b1; addr4 = 32'd1024; wdata4 = 32'h1234_5678;
    lowcnt = 0; w0 = 0; w1 = 0; guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (!ready4) lowcnt++;
      if (!sram_we_n4) begin
        if (sram_addr4 == 18'd0) w0++;
        else if (sram_addr4 == 18'd1) w1++;
      end
    end while (!ready4 && guard < 60);
    chk("w4_done", {31'h0, ready4}, 32'h1);
    @(posedge clk); #1;
    mem_w_en4 = 1'b0;
    chk("w4_freeze", lowcnt, 9);
    chk("w4_we_lo", w0, 3);
    chk("w4_we_hi", w1, 3);
    chk("w4_sram0", {16'h0, sram4[0]}, 32'h0000_5678);
    chk("w4_sram1", {16'h0, sram4[1]}, 32'h0000_1234);

    idle(2);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
